// File: rtl/discrete_rc_node_mc.sv
// Time-multiplexed bank of NCH first-order discrete RC nodes sharing one multiplier.
// Define DISC_RC_SAT_EN to clamp results to DW bits and flag overflow per channel; default wraps.

module discrete_rc_node_mc #(
    parameter int NCH  = 4,
    parameter int NIN  = 3,
    parameter int DW   = 16,
    parameter int CW   = 18,
    parameter int FRAC = 16,
    localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int IDXW = $clog2(NIN + 1)
) (
    input  logic                  clk_msdsl,
    input  logic                  rst_msdsl,
    input  logic                  tick,
    input  logic [NCH*NIN*DW-1:0] x_in,
    input  logic                  coef_we,
    input  logic [CHW-1:0]        coef_ch,
    input  logic [IDXW-1:0]       coef_idx,
    input  logic [CW-1:0]         coef_wdata,
    output logic [NCH*DW-1:0]     v_out,
    output logic                  busy,
    output logic                  done,
    output logic [NCH-1:0]        ovf,
    output logic                  tick_miss,
    output logic                  coef_err
);
    localparam int PW = DW + CW;
    localparam int AW = DW + CW + IDXW;
    localparam logic signed [AW:0] ROUND_HALF = (AW+1)'(1) << (FRAC - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_WB, ST_COMMIT} state_t;

    state_t               state_q;
    logic [CHW-1:0]       ch_q;
    logic [IDXW-1:0]      term_q;
    logic signed [AW-1:0] acc_q;
    logic                 busy_q, done_q, tick_miss_q, coef_err_q;
    logic signed [CW-1:0] coef_q   [NCH][NIN+1];
    logic signed [DW-1:0] v_q      [NCH];
    logic signed [DW-1:0] shadow_q [NCH];
    logic signed [DW-1:0] xs_q     [NCH][NIN];
    logic                 pend_valid_q;
    logic [CHW-1:0]       pend_ch_q;
    logic [IDXW-1:0]      pend_idx_q;
    logic signed [CW-1:0] pend_data_q;

    logic signed [DW-1:0] operand;
    logic signed [PW-1:0] prod;
    logic signed [DW-1:0] wb_val;
    logic                 start;
    logic                 coef_ok;

    assign start   = (state_q == ST_IDLE) && tick;
    assign coef_ok = (int'(coef_ch) < NCH) && (int'(coef_idx) <= NIN);

    // Term 0 multiplies the committed state, terms 1..NIN the snapshot inputs.
    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        operand = v_q[ch_q];
        if (term_q != '0)
            operand = xs_q[ch_q][term_q - IDXW'(1)];
    end

    assign prod = PW'(operand) * PW'(coef_q[ch_q][term_q]);

`ifdef DISC_RC_SAT_EN
    localparam logic signed [AW:0] SAT_MAX = ((AW+1)'(1) << (DW - 1)) - (AW+1)'(1);
    localparam logic signed [AW:0] SAT_MIN = ~SAT_MAX;

    logic signed [AW:0] r_full;
    logic               wb_clip;
    logic [NCH-1:0]     ovf_q;

    assign r_full = ((AW+1)'(acc_q) + ROUND_HALF) >>> FRAC;

    always_comb begin
        wb_val  = r_full[DW-1:0];
        wb_clip = 1'b0;
        if (r_full > SAT_MAX) begin
            wb_val  = SAT_MAX[DW-1:0];
            wb_clip = 1'b1;
        end else if (r_full < SAT_MIN) begin
            wb_val  = SAT_MIN[DW-1:0];
            wb_clip = 1'b1;
        end
    end

    always_ff @(posedge clk_msdsl) begin
        if (rst_msdsl)
            ovf_q <= '0;
        else if ((state_q == ST_WB) && wb_clip)
            ovf_q[ch_q] <= 1'b1;
    end

    assign ovf = ovf_q;
`else
    assign wb_val = DW'(((AW+1)'(acc_q) + ROUND_HALF) >>> FRAC);
    assign ovf    = '0;
`endif

    always_ff @(posedge clk_msdsl) begin
        if (rst_msdsl) begin
            state_q      <= ST_IDLE;
            ch_q         <= '0;
            term_q       <= '0;
            acc_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            tick_miss_q  <= 1'b0;
            coef_err_q   <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_ch_q    <= '0;
            pend_idx_q   <= '0;
            pend_data_q  <= '0;
            // NOTE: coefficients and states are architecturally visible, so they
            // reset; the input snapshot and shadow are always written before use.
            for (int c = 0; c < NCH; c++) begin
                v_q[c] <= '0;
                for (int i = 0; i <= NIN; i++)
                    coef_q[c][i] <= '0;
            end
        end else begin
            done_q <= 1'b0;

            if (tick && busy_q)
                tick_miss_q <= 1'b1;

            // A write arriving with the starting tick is parked until commit,
            // so the pass it coincides with still sees the old coefficient.
            if (coef_we) begin
                if (busy_q) begin
                    coef_err_q <= 1'b1;
                end else if (coef_ok) begin
                    if (tick) begin
                        pend_valid_q <= 1'b1;
                        pend_ch_q    <= coef_ch;
                        pend_idx_q   <= coef_idx;
                        pend_data_q  <= coef_wdata;
                    end else begin
                        coef_q[coef_ch][coef_idx] <= coef_wdata;
                    end
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (tick) begin
                        state_q <= ST_MAC;
                        busy_q  <= 1'b1;
                        ch_q    <= '0;
                        term_q  <= '0;
                        acc_q   <= '0;
                    end
                end
                ST_MAC: begin
                    acc_q <= acc_q + AW'(prod);
                    if (term_q == IDXW'(NIN))
                        state_q <= ST_WB;
                    else
                        term_q <= term_q + IDXW'(1);
                end
                ST_WB: begin
                    acc_q  <= '0;
                    term_q <= '0;
                    if (ch_q == CHW'(NCH - 1)) begin
                        state_q <= ST_COMMIT;
                    end else begin
                        ch_q    <= ch_q + CHW'(1);
                        state_q <= ST_MAC;
                    end
                end
                ST_COMMIT: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    for (int c = 0; c < NCH; c++)
                        v_q[c] <= shadow_q[c];
                    if (pend_valid_q) begin
                        coef_q[pend_ch_q][pend_idx_q] <= pend_data_q;
                        pend_valid_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_msdsl) begin
        if (start) begin
            for (int c = 0; c < NCH; c++)
                for (int i = 0; i < NIN; i++)
                    xs_q[c][i] <= x_in[(c*NIN + i)*DW +: DW];
        end
        if (state_q == ST_WB)
            shadow_q[ch_q] <= wb_val;
    end

    for (genvar c = 0; c < NCH; c++) begin : g_vout
        assign v_out[c*DW +: DW] = v_q[c];
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign tick_miss = tick_miss_q;
    assign coef_err  = coef_err_q;

endmodule

// File: tb/tb_discrete_rc_node_mc.sv
// Self-checking bench for discrete_rc_node_mc (NCH=2, NIN=3): directed cases plus
// randomized passes compared against an arithmetic reference model.

module tb_discrete_rc_node_mc;
    localparam int NCH = 2, NIN = 3, DW = 16, CW = 18, FRAC = 16, LAT = 11;

    logic                  clk_msdsl = 1'b0;
    logic                  rst_msdsl = 1'b1;
    logic                  tick = 1'b0;
    logic [NCH*NIN*DW-1:0] x_in = '0;
    logic                  coef_we = 1'b0;
    logic [0:0]            coef_ch = '0;
    logic [1:0]            coef_idx = '0;
    logic [CW-1:0]         coef_wdata = '0;
    logic [NCH*DW-1:0]     v_out;
    logic                  busy, done;
    logic [NCH-1:0]        ovf;
    logic                  tick_miss, coef_err;

    discrete_rc_node_mc #(.NCH(NCH), .NIN(NIN), .DW(DW), .CW(CW), .FRAC(FRAC)) dut (
        .clk_msdsl (clk_msdsl),
        .rst_msdsl (rst_msdsl),
        .tick      (tick),
        .x_in      (x_in),
        .coef_we   (coef_we),
        .coef_ch   (coef_ch),
        .coef_idx  (coef_idx),
        .coef_wdata(coef_wdata),
        .v_out     (v_out),
        .busy      (busy),
        .done      (done),
        .ovf       (ovf),
        .tick_miss (tick_miss),
        .coef_err  (coef_err)
    );

    always #5 clk_msdsl = ~clk_msdsl;

    int n_chk = 0;
    int n_err = 0;

    longint         m_coef [NCH][NIN+1];
    longint         m_v    [NCH];
    longint         xv     [NCH][NIN];
    logic [NCH-1:0] m_ovf;
    logic           m_tick_miss, m_coef_err;

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_v[c] = 0;
            for (int i = 0; i <= NIN; i++) m_coef[c][i] = 0;
        end
        m_ovf = '0;
        m_tick_miss = 1'b0;
        m_coef_err = 1'b0;
    endtask

    // One forward-Euler step: weighted sum, round half up, then clamp or wrap to 16 bits.
    task automatic model_step();
        longint s, r;
        for (int c = 0; c < NCH; c++) begin
            s = m_coef[c][0] * m_v[c];
            for (int i = 1; i <= NIN; i++) s += m_coef[c][i] * xv[c][i-1];
            r = (s + 32768) >>> 16;
`ifdef DISC_RC_SAT_EN
            if (r > 32767) begin r = 32767; m_ovf[c] = 1'b1; end
            else if (r < -32768) begin r = -32768; m_ovf[c] = 1'b1; end
`else
            r = ((r + 32768) & 65535) - 32768;
`endif
            m_v[c] = r;
        end
    endtask

    task automatic step();
        @(posedge clk_msdsl);
        #1;
    endtask

    task automatic drive_x();
        for (int c = 0; c < NCH; c++)
            for (int i = 0; i < NIN; i++)
                x_in[(c*NIN + i)*DW +: DW] = 16'(xv[c][i]);
    endtask

    task automatic write_coef(input int ch, input int idx, input longint val);
        coef_we = 1'b1;
        coef_ch = 1'(ch);
        coef_idx = 2'(idx);
        coef_wdata = 18'(val);
        step();
        coef_we = 1'b0;
        m_coef[ch][idx] = val;
    endtask

    task automatic start_pass(input string tag);
        drive_x();
        model_step();
        tick = 1'b1;
        step();
        tick = 1'b0;
        check({tag, " busy after tick"}, busy, 1);
    endtask

    // Waits (bounded) for done; n0 = edges already elapsed since the accepting edge.
    // Optional pokes drive coef_we / tick into the given edge of the pass.
    task automatic wait_done(input string tag, input int n0, input int poke_we, input int poke_tk);
        int n = n0;
        bit seen = 1'b0;
        while (!seen && n < 40) begin
            if (n + 1 == poke_we) begin
                coef_we = 1'b1;
                coef_ch = 1'($urandom);
                coef_idx = 2'($urandom);
                coef_wdata = 18'($urandom);
            end
            if (n + 1 == poke_tk) tick = 1'b1;
            step();
            coef_we = 1'b0;
            tick = 1'b0;
            n++;
            if (done === 1'b1) seen = 1'b1;
        end
        check({tag, " done latency"}, seen ? n : -1, LAT);
    endtask

    task automatic check_state(input string tag);
        check({tag, " v0"}, $signed(v_out[15:0]), m_v[0]);
        check({tag, " v1"}, $signed(v_out[31:16]), m_v[1]);
        check({tag, " ovf"}, ovf, m_ovf);
        check({tag, " tick_miss"}, tick_miss, m_tick_miss);
        check({tag, " coef_err"}, coef_err, m_coef_err);
        check({tag, " busy"}, busy, 0);
    endtask

    task automatic run_pass(input string tag);
        start_pass(tag);
        wait_done(tag, 0, 0, 0);
        check_state(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses, pw, pt;
        model_reset();
        for (int c = 0; c < NCH; c++)
            for (int i = 0; i < NIN; i++) xv[c][i] = 0;
        drive_x();
        repeat (3) step();
        rst_msdsl = 1'b0;

        // Reset state, then a pass with all-zero coefficients.
        check_state("reset");
        check("reset done", done, 0);
        run_pass("t1");
        step();
        check("t1 done one cycle", done, 0);

        // Basic scaling, feedback and rounding on channel 0.
        xv[0][0] = 16384;
        write_coef(0, 1, 32768);
        run_pass("t2a");
        check("t2a v0 const", $signed(v_out[15:0]), 8192);
        write_coef(0, 0, 32768);
        run_pass("t2b");
        check("t2b v0 const", $signed(v_out[15:0]), 12288);
        write_coef(0, 0, 0);
        xv[0][0] = 1;
        run_pass("t2c");
        check("t2c v0 const", $signed(v_out[15:0]), 1);

        // Channel 1 exceeding full scale on the second pass.
        write_coef(1, 0, 65536);
        write_coef(1, 1, 65536);
        xv[1][0] = 30000;
        run_pass("t3a");
        check("t3a v1 const", $signed(v_out[31:16]), 30000);
        run_pass("t3b");
`ifdef DISC_RC_SAT_EN
        check("t3b v1 const", $signed(v_out[31:16]), 32767);
        check("t3b ovf1 const", ovf[1], 1);
`else
        check("t3b v1 const", $signed(v_out[31:16]), -5536);
        check("t3b ovf const", ovf, 0);
`endif

        // Tick at T and T+3: one pass only; a tick in the done cycle starts the next.
        drive_x();
        model_step();
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
        step();
        tick = 1'b1;
        step();
        tick = 1'b0;
        m_tick_miss = 1'b1;
        wait_done("t4", 3, 0, 0);
        check_state("t4");
        run_pass("t4 done-cycle tick");

        // Coefficient write during a pass is dropped and flagged.
        xv[0][0] = 16384;
        drive_x();
        model_step();
        tick = 1'b1;
        step();
        tick = 1'b0;
        repeat (3) step();
        coef_we = 1'b1;
        coef_ch = 1'b0;
        coef_idx = 2'd1;
        coef_wdata = 18'(65536);
        step();
        coef_we = 1'b0;
        m_coef_err = 1'b1;
        wait_done("t5", 4, 0, 0);
        check_state("t5");
        run_pass("t5 old coef");
        check("t5 v0 const", $signed(v_out[15:0]), 8192);

        // Reset in the middle of a pass aborts it.
        drive_x();
        tick = 1'b1;
        step();
        tick = 1'b0;
        repeat (4) step();
        rst_msdsl = 1'b1;
        step();
        rst_msdsl = 1'b0;
        model_reset();
        check_state("t6 after reset");
        pulses = 0;
        repeat (15) begin
            step();
            if (done === 1'b1) pulses++;
        end
        check("t6 done pulses", pulses, 0);
        write_coef(0, 1, 32768);
        run_pass("t6 resume");
        check("t6 v0 const", $signed(v_out[15:0]), 8192);

        // Tick and coef_we in the same idle cycle: this pass uses the old value.
        drive_x();
        model_step();
        tick = 1'b1;
        coef_we = 1'b1;
        coef_ch = 1'b0;
        coef_idx = 2'd1;
        coef_wdata = 18'(-32768);
        step();
        tick = 1'b0;
        coef_we = 1'b0;
        m_coef[0][1] = -32768;
        check("t7 busy after tick", busy, 1);
        wait_done("t7", 0, 0, 0);
        check_state("t7");
        check("t7 v0 const", $signed(v_out[15:0]), 8192);
        run_pass("t7 new coef");
        check("t7 v0 new const", $signed(v_out[15:0]), -8192);

        // Randomized passes with random mid-pass writes and ticks.
        for (int it = 0; it < 25; it++) begin
            repeat (2) write_coef($urandom_range(0, 1), $urandom_range(0, 3),
                                  longint'($urandom_range(0, 131072)) - 65536);
            for (int c = 0; c < NCH; c++)
                for (int i = 0; i < NIN; i++)
                    xv[c][i] = (it % 3 == 0) ? longint'($urandom_range(0, 65535)) - 32768
                                             : longint'($urandom_range(0, 8000)) - 4000;
            pw = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 11)) : 0;
            pt = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 11)) : 0;
            start_pass("rand");
            if (pw != 0) m_coef_err = 1'b1;
            if (pt != 0) m_tick_miss = 1'b1;
            wait_done("rand", 0, pw, pt);
            check_state("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
